// File: rtl/ps2_scan_rx_if.sv
// Scan-code stream between the PS/2 receiver and the keyboard-command logic.
//   code_valid : head entry presented (producer -> consumer)
//   code_ready : consumer accepts the head entry (consumer -> producer)
//   code       : head scan code
//   code_ext   : head code was preceded by E0
//   code_break : head code was preceded by F0 (key release)
interface ps2_scan_rx_if;
  logic       code_valid;
  logic       code_ready;
  logic [7:0] code;
  logic       code_ext;
  logic       code_break;

  modport master (
    output code_valid,
    output code,
    output code_ext,
    output code_break,
    input  code_ready
  );

  modport slave (
    input  code_valid,
    input  code,
    input  code_ext,
    input  code_break,
    output code_ready
  );
endinterface

// File: rtl/ps2_scan_rx.sv
// PS/2 device-to-host receiver with debounced inputs, frame checking, mid-frame
// timeout, optional E0/F0 prefix decoding and a first-word fall-through code FIFO.
//   clk       : system clock, rising edge
//   reset_n   : asynchronous active-low reset
//   ps2_clk   : raw PS/2 clock line (asynchronous)
//   ps2_data  : raw PS/2 data line (asynchronous)
//   code_if   : valid/ready stream of {ext, break, code} entries
//   frame_err : one-cycle pulse on bad start/parity/stop or timeout
//   overflow  : one-cycle pulse when a decoded code is dropped (FIFO full)
//   busy      : frame in progress
module ps2_scan_rx #(
  parameter int unsigned CLK_FREQ        = 50000000,
  parameter int unsigned DEBOUNCE_CYCLES = 8,
  parameter int unsigned IDLE_CYCLES     = CLK_FREQ / 18000,
  parameter int unsigned FIFO_DEPTH      = 4,
  parameter bit          DECODE_PREFIX   = 1'b1
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          ps2_clk,
  input  logic          ps2_data,
  ps2_scan_rx_if.master code_if,
  output logic          frame_err,
  output logic          overflow,
  output logic          busy
);

  localparam int unsigned DbW = $clog2(DEBOUNCE_CYCLES);
  localparam int unsigned IdW = $clog2(IDLE_CYCLES + 1);
  localparam int unsigned AW  = $clog2(FIFO_DEPTH);

  localparam logic [DbW-1:0] DbMax = DbW'(DEBOUNCE_CYCLES - 1);
  localparam logic [IdW-1:0] IdMax = IdW'(IDLE_CYCLES);

  typedef enum logic [1:0] {StIdle, StExt, StBrk, StExtBrk} dec_state_e;

  // ---------------------------------------------------------------------------
  // Synchronisers and debounce filters
  // ---------------------------------------------------------------------------
  logic [1:0]     clk_sync_q, data_sync_q;
  logic [DbW-1:0] clk_db_q, clk_db_d, data_db_q, data_db_d;
  logic           clk_f_q, clk_f_d, data_f_q, data_f_d;
  logic           clk_prev_q;

  // The counter tracks consecutive samples that disagree with the filtered value;
  // the filtered value flips only after DEBOUNCE_CYCLES of them in a row.
  always_comb begin
    clk_f_d   = clk_f_q;
    clk_db_d  = '0;
    data_f_d  = data_f_q;
    data_db_d = '0;
    if (clk_sync_q[1] != clk_f_q) begin
      if (clk_db_q == DbMax) clk_f_d  = clk_sync_q[1];
      else                   clk_db_d = clk_db_q + 1'b1;
    end
    if (data_sync_q[1] != data_f_q) begin
      if (data_db_q == DbMax) data_f_d  = data_sync_q[1];
      else                    data_db_d = data_db_q + 1'b1;
    end
  end

  // Sync flops clear to 0; the debounce filter masks the two-cycle mismatch
  // against the filtered lines, which come out of reset high.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      clk_sync_q  <= '0;
      data_sync_q <= '0;
      clk_db_q    <= '0;
      data_db_q   <= '0;
      clk_f_q     <= 1'b1;
      data_f_q    <= 1'b1;
      clk_prev_q  <= 1'b1;
    end else begin
      clk_sync_q  <= {clk_sync_q[0], ps2_clk};
      data_sync_q <= {data_sync_q[0], ps2_data};
      clk_db_q    <= clk_db_d;
      data_db_q   <= data_db_d;
      clk_f_q     <= clk_f_d;
      data_f_q    <= data_f_d;
      clk_prev_q  <= clk_f_q;
    end
  end

  // ---------------------------------------------------------------------------
  // Bit capture, idle timer and frame check
  // ---------------------------------------------------------------------------
  logic           strobe, last_bit, frame_ok, timeout;
  logic [10:0]    frame;
  logic [9:0]     shift_q, shift_d;
  logic [3:0]     bit_cnt_q, bit_cnt_d;
  logic [IdW-1:0] idle_q, idle_d;
  logic           rx_good_q, rx_good_d, rx_bad_q, rx_bad_d, err_q, err_d;

  assign strobe   = clk_prev_q & ~clk_f_q;
  // Frame as it stands once the current data bit is shifted in (LSB first).
  assign frame    = {data_f_q, shift_q};
  assign last_bit = strobe && (bit_cnt_q == 4'd10);
  assign frame_ok = ~frame[0] & (^frame[9:1]) & frame[10];
  assign timeout  = (idle_q == IdMax) && (bit_cnt_q != 4'd0);

  always_comb begin
    idle_d = '0;
    if (clk_f_q) idle_d = (idle_q == IdMax) ? idle_q : idle_q + 1'b1;
  end

  always_comb begin
    shift_d   = shift_q;
    bit_cnt_d = bit_cnt_q;
    rx_good_d = 1'b0;
    rx_bad_d  = 1'b0;
    err_d     = 1'b0;
    if (strobe) begin
      shift_d = frame[10:1];
      if (last_bit) begin
        bit_cnt_d = 4'd0;
        rx_good_d = frame_ok;
        rx_bad_d  = ~frame_ok;
        err_d     = ~frame_ok;
      end else begin
        bit_cnt_d = bit_cnt_q + 4'd1;
      end
    end else if (timeout) begin
      bit_cnt_d = 4'd0;
      err_d     = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      shift_q   <= '0;
      bit_cnt_q <= '0;
      idle_q    <= '0;
      rx_good_q <= 1'b0;
      rx_bad_q  <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      shift_q   <= shift_d;
      bit_cnt_q <= bit_cnt_d;
      idle_q    <= idle_d;
      rx_good_q <= rx_good_d;
      rx_bad_q  <= rx_bad_d;
      err_q     <= err_d;
    end
  end

  // After the final strobe the data byte sits in shift_q[7:0].
  logic [7:0] rx_byte;
  assign rx_byte = shift_q[7:0];

  // ---------------------------------------------------------------------------
  // Prefix decoder
  // ---------------------------------------------------------------------------
  dec_state_e dec_q, dec_d;
  logic       push;
  logic [9:0] push_data;

  always_comb begin
    dec_d     = dec_q;
    push      = 1'b0;
    push_data = {2'b00, rx_byte};
    if (rx_bad_q) begin
      dec_d = StIdle;
    end else if (rx_good_q) begin
      if (DECODE_PREFIX == 1'b0) begin
        push = 1'b1;
      end else begin
        unique case (dec_q)
          StIdle: begin
            if (rx_byte == 8'hE0)      dec_d = StExt;
            else if (rx_byte == 8'hF0) dec_d = StBrk;
            else                       push  = 1'b1;
          end
          StExt: begin
            if (rx_byte == 8'hF0) begin
              dec_d = StExtBrk;
            end else if (rx_byte != 8'hE0) begin
              push      = 1'b1;
              push_data = {2'b10, rx_byte};
              dec_d     = StIdle;
            end
          end
          StBrk: begin
            if (rx_byte != 8'hE0 && rx_byte != 8'hF0) begin
              push      = 1'b1;
              push_data = {2'b01, rx_byte};
              dec_d     = StIdle;
            end
          end
          StExtBrk: begin
            if (rx_byte != 8'hE0 && rx_byte != 8'hF0) begin
              push      = 1'b1;
              push_data = {2'b11, rx_byte};
              dec_d     = StIdle;
            end
          end
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) dec_q <= StIdle;
    else          dec_q <= dec_d;
  end

  // ---------------------------------------------------------------------------
  // Code FIFO (first-word fall-through, pointers carry a wrap bit)
  // ---------------------------------------------------------------------------
  logic [9:0] mem_q [FIFO_DEPTH];
  logic [AW:0] wr_q, rd_q;
  logic        empty, full, pop, wr_en, ovf_q;

  assign empty = (wr_q == rd_q);
  assign full  = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
  assign pop   = ~empty & code_if.code_ready;
  // A pop frees the slot the push writes into, so full+pop still accepts.
  assign wr_en = push & (~full | pop);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
      wr_q  <= '0;
      rd_q  <= '0;
      ovf_q <= 1'b0;
    end else begin
      if (wr_en) begin
        mem_q[wr_q[AW-1:0]] <= push_data;
        wr_q                <= wr_q + 1'b1;
      end
      if (pop) rd_q <= rd_q + 1'b1;
      ovf_q <= push & full & ~pop;
    end
  end

  assign code_if.code_valid = ~empty;
  assign code_if.code_ext   = mem_q[rd_q[AW-1:0]][9];
  assign code_if.code_break = mem_q[rd_q[AW-1:0]][8];
  assign code_if.code       = mem_q[rd_q[AW-1:0]][7:0];
  assign frame_err          = err_q;
  assign overflow           = ovf_q;
  assign busy               = (bit_cnt_q != 4'd0);

endmodule

// File: tb/tb_ps2_scan_rx.sv
module tb_ps2_scan_rx;
  localparam int unsigned ClkFreq = 1000000;  // 12.5 kHz PS/2 -> 80 clk per bit

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic ps2_clk = 1'b1;
  logic ps2_data = 1'b1;
  logic fe, ov, bz, fe_r, ov_r, bz_r;

  always #5 clk = ~clk;

  ps2_scan_rx_if cif ();
  ps2_scan_rx_if rif ();

  ps2_scan_rx #(
    .CLK_FREQ(ClkFreq), .DEBOUNCE_CYCLES(8), .IDLE_CYCLES(ClkFreq / 18000),
    .FIFO_DEPTH(4), .DECODE_PREFIX(1'b1)
  ) dut (
    .clk(clk), .reset_n(reset_n), .ps2_clk(ps2_clk), .ps2_data(ps2_data),
    .code_if(cif), .frame_err(fe), .overflow(ov), .busy(bz)
  );

  ps2_scan_rx #(
    .CLK_FREQ(ClkFreq), .DEBOUNCE_CYCLES(8), .IDLE_CYCLES(ClkFreq / 18000),
    .FIFO_DEPTH(4), .DECODE_PREFIX(1'b0)
  ) dut_raw (
    .clk(clk), .reset_n(reset_n), .ps2_clk(ps2_clk), .ps2_data(ps2_data),
    .code_if(rif), .frame_err(fe_r), .overflow(ov_r), .busy(bz_r)
  );

  logic [9:0] q_main[$];
  logic [9:0] q_raw[$];
  int n_cmp = 0;
  int n_bad = 0;
  int fe_cnt = 0;
  int ov_cnt = 0;

  // Scoreboard: every accepted beat is popped against the expected queue.
  always @(negedge clk) begin
    logic [9:0] exp_v;
    if (reset_n) begin
      if (fe) fe_cnt++;
      if (ov) ov_cnt++;
      if (cif.code_valid && cif.code_ready) begin
        n_cmp++;
        if (q_main.size() == 0) begin
          n_bad++;
          $display("FAIL main_beat: got %h required no beat",
                   {cif.code_ext, cif.code_break, cif.code});
        end else begin
          exp_v = q_main.pop_front();
          if ({cif.code_ext, cif.code_break, cif.code} !== exp_v) begin
            n_bad++;
            $display("FAIL main_beat: got %h required %h",
                     {cif.code_ext, cif.code_break, cif.code}, exp_v);
          end
        end
      end
      if (rif.code_valid && rif.code_ready) begin
        n_cmp++;
        if (q_raw.size() == 0) begin
          n_bad++;
          $display("FAIL raw_beat: got %h required no beat",
                   {rif.code_ext, rif.code_break, rif.code});
        end else begin
          exp_v = q_raw.pop_front();
          if ({rif.code_ext, rif.code_break, rif.code} !== exp_v) begin
            n_bad++;
            $display("FAIL raw_beat: got %h required %h",
                     {rif.code_ext, rif.code_break, rif.code}, exp_v);
          end
        end
      end
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  function automatic logic [10:0] mk_frame(input logic [7:0] b, input logic bad_par);
    return {1'b1, ~(^b) ^ bad_par, b, 1'b0};
  endfunction

  task automatic send_bits(input logic [10:0] fr, input int nbits);
    for (int i = 0; i < nbits; i++) begin
      ps2_data = fr[i];
      cyc(20);
      ps2_clk = 1'b0;
      cyc(40);
      ps2_clk = 1'b1;
      cyc(20);
    end
    ps2_data = 1'b1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    send_bits(mk_frame(b, 1'b0), 11);
    cyc(120);
  endtask

  task automatic expect_drained(input string name);
    n_cmp++;
    if (q_main.size() != 0 || q_raw.size() != 0) begin
      n_bad++;
      $display("FAIL %s_drained: got %0d/%0d pending required 0/0", name,
               q_main.size(), q_raw.size());
    end
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    cif.code_ready = 1'b1;
    rif.code_ready = 1'b1;
    cyc(3);
    n_cmp++;
    if ({cif.code_valid, cif.code, cif.code_ext, cif.code_break, fe, ov, bz} !== 14'd0) begin
      n_bad++;
      $display("FAIL reset_main: got %b required 0",
               {cif.code_valid, cif.code, cif.code_ext, cif.code_break, fe, ov, bz});
    end
    n_cmp++;
    if ({rif.code_valid, rif.code, rif.code_ext, rif.code_break, fe_r, ov_r, bz_r} !== 14'd0)
    begin
      n_bad++;
      $display("FAIL reset_raw: got %b required 0",
               {rif.code_valid, rif.code, rif.code_ext, rif.code_break, fe_r, ov_r, bz_r});
    end
    reset_n = 1'b1;
    cyc(100);
  endtask

  task automatic test_single();
    int fe0 = fe_cnt;
    q_main.push_back({2'b00, 8'h1C});
    q_raw.push_back({2'b00, 8'h1C});
    send_byte(8'h1C);
    expect_drained("single");
    n_cmp++;
    if (fe_cnt != fe0) begin
      n_bad++;
      $display("FAIL single_frame_err: got %0d pulses required 0", fe_cnt - fe0);
    end
  endtask

  task automatic test_prefix();
    logic [7:0] seq [5] = '{8'hE0, 8'hF0, 8'h75, 8'hF0, 8'h1C};
    int fe0 = fe_cnt;
    q_main.push_back({2'b11, 8'h75});
    q_main.push_back({2'b01, 8'h1C});
    for (int i = 0; i < 5; i++) begin
      q_raw.push_back({2'b00, seq[i]});
      send_byte(seq[i]);
    end
    expect_drained("prefix");
    n_cmp++;
    if (fe_cnt != fe0) begin
      n_bad++;
      $display("FAIL prefix_frame_err: got %0d pulses required 0", fe_cnt - fe0);
    end
  endtask

  task automatic test_parity();
    int fe0;
    q_raw.push_back({2'b00, 8'hE0});
    send_byte(8'hE0);
    fe0 = fe_cnt;
    send_bits(mk_frame(8'h1C, 1'b1), 11);
    cyc(120);
    n_cmp++;
    if (fe_cnt - fe0 != 1) begin
      n_bad++;
      $display("FAIL parity_frame_err: got %0d pulses required 1", fe_cnt - fe0);
    end
    q_main.push_back({2'b00, 8'h32});
    q_raw.push_back({2'b00, 8'h32});
    send_byte(8'h32);
    expect_drained("parity");
  endtask

  task automatic test_timeout();
    int fe0 = fe_cnt;
    int waited = 0;
    send_bits(mk_frame(8'h55, 1'b0), 5);
    n_cmp++;
    if (bz !== 1'b1) begin
      n_bad++;
      $display("FAIL timeout_busy_mid: got %b required 1", bz);
    end
    while (fe_cnt == fe0 && waited < 200) begin
      cyc(1);
      waited++;
    end
    cyc(20);
    n_cmp++;
    if (fe_cnt - fe0 != 1) begin
      n_bad++;
      $display("FAIL timeout_frame_err: got %0d pulses required 1", fe_cnt - fe0);
    end
    n_cmp++;
    if (bz !== 1'b0) begin
      n_bad++;
      $display("FAIL timeout_busy_after: got %b required 0", bz);
    end
    cyc(100);
    q_main.push_back({2'b00, 8'h29});
    q_raw.push_back({2'b00, 8'h29});
    send_byte(8'h29);
    expect_drained("timeout");
  endtask

  task automatic test_overflow();
    int ov0 = ov_cnt;
    cif.code_ready = 1'b0;
    for (int i = 1; i <= 6; i++) begin
      if (i <= 4) q_main.push_back({2'b00, 8'(i)});
      q_raw.push_back({2'b00, 8'(i)});
      send_byte(8'(i));
      if (i == 1 || i == 6) begin
        n_cmp++;
        if (cif.code_valid !== 1'b1 || cif.code !== 8'h01) begin
          n_bad++;
          $display("FAIL overflow_head_hold: got valid=%b code=%h required valid=1 code=01",
                   cif.code_valid, cif.code);
        end
      end
    end
    n_cmp++;
    if (ov_cnt - ov0 != 2) begin
      n_bad++;
      $display("FAIL overflow_pulses: got %0d required 2", ov_cnt - ov0);
    end
    cif.code_ready = 1'b1;
    cyc(10);
    expect_drained("overflow");
    n_cmp++;
    if (cif.code_valid !== 1'b0) begin
      n_bad++;
      $display("FAIL overflow_empty: got valid=%b required 0", cif.code_valid);
    end
  endtask

  task automatic test_glitch();
    int fe0 = fe_cnt;
    ps2_clk = 1'b0;
    cyc(3);
    ps2_clk = 1'b1;
    cyc(5);
    n_cmp++;
    if (bz !== 1'b0) begin
      n_bad++;
      $display("FAIL glitch_busy: got %b required 0", bz);
    end
    cyc(100);
    n_cmp++;
    if (fe_cnt != fe0) begin
      n_bad++;
      $display("FAIL glitch_frame_err: got %0d pulses required 0", fe_cnt - fe0);
    end
  endtask

  task automatic test_reset_mid();
    int fe0;
    send_bits(mk_frame(8'h44, 1'b0), 5);
    reset_n = 1'b0;
    cyc(2);
    n_cmp++;
    if ({cif.code_valid, cif.code, cif.code_ext, cif.code_break, fe, ov, bz} !== 14'd0) begin
      n_bad++;
      $display("FAIL reset_mid_outputs: got %b required 0",
               {cif.code_valid, cif.code, cif.code_ext, cif.code_break, fe, ov, bz});
    end
    cyc(2);
    reset_n = 1'b1;
    fe0 = fe_cnt;
    cyc(100);
    n_cmp++;
    if (fe_cnt != fe0 || bz !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_mid_quiet: got %0d pulses busy=%b required 0 pulses busy=0",
               fe_cnt - fe0, bz);
    end
    q_main.push_back({2'b00, 8'h29});
    q_raw.push_back({2'b00, 8'h29});
    send_byte(8'h29);
    expect_drained("reset_mid");
  endtask

  initial begin
    test_reset();
    test_single();
    test_prefix();
    test_parity();
    test_timeout();
    test_overflow();
    test_glitch();
    test_reset_mid();
    cyc(20);
    expect_drained("final");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #3ms;
    $display("FAIL watchdog: got no finish required finish within 3 ms");
    $fatal(1, "watchdog expired");
  end
endmodule
